backend_pipe_regs: RTL and testbench

//  Parametrised backend pipeline-register array: LANES parallel issue lanes by STAGES

---
 rtl/backend_pipe_regs.sv | 149 ++++++++++++++
 tb/tb_backend_pipe_regs.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/backend_pipe_regs.sv
// Backend pipeline-register array: LANES issue lanes by STAGES stages carrying valid/data/ctrl/rd.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module backend_pipe_regs #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned STAGES = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             stall_i,
    input  logic [LANES-1:0]                 kill_i,
    input  logic [STAGES-1:0]                flush_i,
    input  logic [LANES-1:0]                 in_valid_i,
    input  logic [LANES*DATA_W-1:0]          in_data_i,
    input  logic [LANES*CTRL_W-1:0]          in_ctrl_i,
    input  logic [LANES*5-1:0]               in_rd_i,
    input  logic [STAGES*LANES-1:0]          res_we_i,
    input  logic [STAGES*LANES*DATA_W-1:0]   res_data_i,
    output logic                             adv_o,
    output logic [STAGES*LANES-1:0]          stg_valid_o,
    output logic [STAGES*LANES*DATA_W-1:0]   stg_data_o,
    output logic [STAGES*LANES*CTRL_W-1:0]   stg_ctrl_o,
    output logic [STAGES*LANES*5-1:0]        stg_rd_o,
    output logic [31:0]                      stall_cnt_o,
    output logic [31:0]                      bubble_cnt_o
);

    localparam int unsigned Slots = STAGES * LANES;
    localparam int unsigned Last  = (STAGES - 1) * LANES;

    logic [Slots-1:0]        valid_q, valid_d;
    logic [Slots*DATA_W-1:0] data_q, data_d;
    logic [Slots*CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [Slots*5-1:0]      rd_q, rd_d;

    assign adv_o = !stall_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        rd_d    = rd_q;
        if (!stall_i) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (kill_i[l] || !in_valid_i[l]) begin
                    valid_d[l]                  = 1'b0;
                    data_d[l*DATA_W +: DATA_W]  = '0;
                    ctrl_d[l*CTRL_W +: CTRL_W]  = '0;
                    rd_d[l*5 +: 5]              = '0;
                end else begin
                    valid_d[l]                  = 1'b1;
                    data_d[l*DATA_W +: DATA_W]  = in_data_i[l*DATA_W +: DATA_W];
                    ctrl_d[l*CTRL_W +: CTRL_W]  = in_ctrl_i[l*CTRL_W +: CTRL_W];
                    rd_d[l*5 +: 5]              = in_rd_i[l*5 +: 5];
                end
            end
            // Later stages copy their predecessor; a stage result may replace the data.
            for (int unsigned s = 1; s < STAGES; s++) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    valid_d[s*LANES+l] = valid_q[(s-1)*LANES+l];
                    ctrl_d[(s*LANES+l)*CTRL_W +: CTRL_W] = ctrl_q[((s-1)*LANES+l)*CTRL_W +: CTRL_W];
                    rd_d[(s*LANES+l)*5 +: 5] = rd_q[((s-1)*LANES+l)*5 +: 5];
                    if (res_we_i[(s-1)*LANES+l]) begin
                        data_d[(s*LANES+l)*DATA_W +: DATA_W] =
                            res_data_i[((s-1)*LANES+l)*DATA_W +: DATA_W];
                    end else begin
                        data_d[(s*LANES+l)*DATA_W +: DATA_W] =
                            data_q[((s-1)*LANES+l)*DATA_W +: DATA_W];
                    end
                end
            end
        end
        // Flush wins over hold and advance; data is left alone.
        for (int unsigned s = 0; s < STAGES; s++) begin
            if (flush_i[s]) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    valid_d[s*LANES+l]                   = 1'b0;
                    ctrl_d[(s*LANES+l)*CTRL_W +: CTRL_W] = '0;
                    rd_d[(s*LANES+l)*5 +: 5]             = '0;
                end
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
        end
    end

    assign stg_valid_o = valid_q;
    assign stg_data_o  = data_q;
    assign stg_ctrl_o  = ctrl_q;
    assign stg_rd_o    = rd_q;

    // The last stage has no successor, so its result inputs go nowhere.
    logic unused_res;
    assign unused_res = ^{res_we_i[Last +: LANES], res_data_i[Last*DATA_W +: LANES*DATA_W]};

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] bub_num;
    logic [32:0] bub_sum;

    always_comb begin
        bub_num = '0;
        if (!stall_i) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (kill_i[l] || !in_valid_i[l]) begin
                    bub_num = bub_num + 32'd1;
                end
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        bub_sum      = {1'b0, bubble_cnt_q} + {1'b0, bub_num};
        bubble_cnt_d = bub_sum[32] ? 32'hFFFF_FFFF : bub_sum[31:0];
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_backend_pipe_regs.sv
// Directed bench for backend_pipe_regs at default parameters (2 lanes, 3 stages).
module tb_backend_pipe_regs;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         stall_i;
    logic [1:0]   kill_i;
    logic [2:0]   flush_i;
    logic [1:0]   in_valid_i;
    logic [63:0]  in_data_i;
    logic [31:0]  in_ctrl_i;
    logic [9:0]   in_rd_i;
    logic [5:0]   res_we_i;
    logic [191:0] res_data_i;
    logic         adv_o;
    logic [5:0]   stg_valid_o;
    logic [191:0] stg_data_o;
    logic [95:0]  stg_ctrl_o;
    logic [29:0]  stg_rd_o;
    logic [31:0]  stall_cnt_o;
    logic [31:0]  bubble_cnt_o;

    int n_pass  = 0;
    int n_total = 0;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    backend_pipe_regs dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .stall_i      (stall_i),
        .kill_i       (kill_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ctrl_i    (in_ctrl_i),
        .in_rd_i      (in_rd_i),
        .res_we_i     (res_we_i),
        .res_data_i   (res_data_i),
        .adv_o        (adv_o),
        .stg_valid_o  (stg_valid_o),
        .stg_data_o   (stg_data_o),
        .stg_ctrl_o   (stg_ctrl_o),
        .stg_rd_o     (stg_rd_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        // Reset with arbitrary inputs, no clock edge yet.
        reset_i    = 1'b1;
        stall_i    = 1'b1;
        kill_i     = 2'b01;
        flush_i    = 3'b101;
        in_valid_i = 2'b11;
        in_data_i  = 64'h1234_5678_9ABC_DEF0;
        in_ctrl_i  = 32'hFFFF_FFFF;
        in_rd_i    = 10'h3FF;
        res_we_i   = 6'h3F;
        res_data_i = {6{32'hCAFE_F00D}};
        #2;
        check("rst_valid", stg_valid_o, 6'b0);
        check("rst_data", stg_data_o, 192'b0);
        check("rst_ctrl", stg_ctrl_o, 96'b0);
        check("rst_rd", stg_rd_o, 30'b0);
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        check("rst_bubble_cnt", bubble_cnt_o, 32'd0);
        check("rst_adv", adv_o, 1'b0);

        // Release and stream 0x100/0x104 in both lanes.
        #1;
        reset_i    = 1'b0;
        stall_i    = 1'b0;
        kill_i     = 2'b00;
        flush_i    = 3'b000;
        res_we_i   = 6'h00;
        res_data_i = '0;
        in_data_i  = {32'h104, 32'h100};
        in_ctrl_i  = {16'h00B2, 16'h00A1};
        in_rd_i    = {5'd7, 5'd3};
        #1;
        check("flow_adv", adv_o, 1'b1);
        tick();
        check("flow_valid_e1", stg_valid_o, 6'b000011);
        tick();
        check("flow_valid_e2", stg_valid_o, 6'b001111);
        tick();
        check("flow_valid_e3", stg_valid_o, 6'b111111);
        check("flow_data_e3", stg_data_o, {3{32'h104, 32'h100}});
        check("flow_ctrl_e3", stg_ctrl_o, {3{16'h00B2, 16'h00A1}});
        check("flow_rd_e3", stg_rd_o, {3{5'd7, 5'd3}});

        // Stage 0 lane 1 result replaces the data passed to stage 1.
        res_we_i   = 6'b000010;
        res_data_i[32 +: 32] = 32'hDEAD;
        tick();
        check("ovr_data", stg_data_o,
              {32'h104, 32'h100, 32'hDEAD, 32'h100, 32'h104, 32'h100});
        res_we_i   = 6'b000000;
        res_data_i = '0;
        tick();
        check("ovr_data_next", stg_data_o,
              {32'hDEAD, 32'h100, 32'h104, 32'h100, 32'h104, 32'h100});

        // Four stall cycles; kill/res_we/new inputs must be ignored; flush stage 1 in cycle 2.
        stall_i    = 1'b1;
        kill_i     = 2'b11;
        res_we_i   = 6'h3F;
        res_data_i = {6{32'hBAD0_BAD0}};
        in_valid_i = 2'b00;
        in_data_i  = {32'h204, 32'h200};
        #1;
        check("stall_adv", adv_o, 1'b0);
        tick();
        check("stall_valid_c1", stg_valid_o, 6'b111111);
        check("stall_data_c1", stg_data_o,
              {32'hDEAD, 32'h100, 32'h104, 32'h100, 32'h104, 32'h100});
        flush_i = 3'b010;
        tick();
        flush_i = 3'b000;
        check("flush_valid_c2", stg_valid_o, 6'b110011);
        check("flush_ctrl_c2", stg_ctrl_o, {16'h00B2, 16'h00A1, 32'h0, 16'h00B2, 16'h00A1});
        check("flush_rd_c2", stg_rd_o, {5'd7, 5'd3, 10'd0, 5'd7, 5'd3});
        check("flush_adv_c2", adv_o, 1'b0);
        tick();
        tick();
        check("stall_valid_c4", stg_valid_o, 6'b110011);
        check("stall_data_c4", stg_data_o,
              {32'hDEAD, 32'h100, 32'h104, 32'h100, 32'h104, 32'h100});
        check("stall_cnt", stall_cnt_o, PerfEn ? 32'd4 : 32'd0);
        check("stall_bubble_cnt", bubble_cnt_o, 32'd0);

        // Kill lane 1 on advance.
        stall_i    = 1'b0;
        kill_i     = 2'b10;
        res_we_i   = 6'h00;
        res_data_i = '0;
        in_valid_i = 2'b11;
        in_data_i  = {32'h304, 32'h300};
        in_ctrl_i  = {16'h00D2, 16'h00D1};
        in_rd_i    = {5'd9, 5'd8};
        tick();
        check("bub_valid", stg_valid_o, 6'b001101);
        check("bub_ctrl", stg_ctrl_o, {32'h0, 16'h00B2, 16'h00A1, 16'h0, 16'h00D1});
        check("bub_rd", stg_rd_o, {10'd0, 5'd7, 5'd3, 5'd0, 5'd8});
        check("bub_data_s0", stg_data_o[63:0], {32'h0, 32'h300});
        check("bub_cnt1", bubble_cnt_o, PerfEn ? 32'd1 : 32'd0);

        // Lane 0 not valid -> bubble in lane 0 only.
        kill_i     = 2'b00;
        in_valid_i = 2'b10;
        in_data_i  = {32'h404, 32'h400};
        in_ctrl_i  = {16'h00E2, 16'h00E1};
        in_rd_i    = {5'd10, 5'd11};
        tick();
        check("inv_valid", stg_valid_o, 6'b110110);
        check("inv_ctrl_s0", stg_ctrl_o[31:0], {16'h00E2, 16'h0});
        check("inv_cnt2", bubble_cnt_o, PerfEn ? 32'd2 : 32'd0);

        // Async reset between edges.
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_valid", stg_valid_o, 6'b0);
        check("arst_data", stg_data_o, 192'b0);
        check("arst_ctrl", stg_ctrl_o, 96'b0);
        check("arst_rd", stg_rd_o, 30'b0);
        check("arst_bubble_cnt", bubble_cnt_o, 32'd0);
        check("arst_stall_cnt", stall_cnt_o, 32'd0);
        reset_i    = 1'b0;
        in_valid_i = 2'b11;
        tick();
        check("refill_valid", stg_valid_o, 6'b000011);
        check("refill_data", stg_data_o, {128'h0, 32'h404, 32'h400});
        check("refill_rd", stg_rd_o, {20'd0, 5'd10, 5'd11});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
